// File: rtl/bist_pkg.sv
// bist_pkg
// Shared definitions for the circular-BIST sequencer: FSM state encoding,
// default widths and the bit used to build the zero-seed substitute.
// Ports: none (package).
// Optional feature macro used by bist_controller: BIST_DOUBLE_RUN_EN.
package bist_pkg;

  localparam int BIST_SIG_WIDTH  = 8;
  localparam int BIST_SEED_WIDTH = 4;
  localparam int BIST_CNT_WIDTH  = 8;

  // An all-zero seed locks the LFSR, so it is replaced by this bit
  // replicated across the seed width (all-ones).
  localparam logic SEED_SUBST_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

endpackage

// File: rtl/bist_run_counter.sv
// bist_run_counter
// Loadable up-counter that times the RUN phase. Clear has priority over
// load, load over enable. tc flags the last enabled cycle of a run
// (count == TEST_CYCLES-1).
// Ports:
//   clock, reset (async, active-low)
//   clear     - synchronous clear to zero
//   load      - synchronous load of load_val
//   load_val  - value for load
//   enable    - count up by one
//   tc        - terminal-count flag
module bist_run_counter #(
  parameter int CNT_WIDTH   = 8,
  parameter int TEST_CYCLES = 200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 enable,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_WIDTH'(TEST_CYCLES - 1));

endmodule

// File: rtl/bist_controller.sv
// bist_controller
// Sequencer for the circular-BIST session: latches a seed on start, loads
// it into the chain, clocks the chain for TEST_CYCLES cycles, captures the
// signature and compares it with GOLDEN_SIG. All outputs are registered.
// Optional feature: define BIST_DOUBLE_RUN_EN to run two passes with the
// same seed; pass requires both signatures to match GOLDEN_SIG and each
// other, and signature_out holds the second one.
// Ports:
//   clock, reset (async, active-low)
//   bist_start    - start request, honoured in IDLE and DONE only
//   lfsr_seed     - seed, sampled when the start is accepted
//   signature_in  - live chain contents
//   seed_out      - seed presented to the chain (valid with seed_load)
//   seed_load     - one-cycle chain seed load strobe
//   bist_mode     - test-path select for chain/arbiter muxes
//   chain_enable  - advances the circular chain
//   busy          - session in progress
//   bist_end      - session complete
//   pass_fail     - 1 = signature matched
//   signature_out - captured signature
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, results cleared
// LOAD    | seed_load strobe, run counter cleared
// RUN     | chain enabled for TEST_CYCLES cycles
// CAPTURE | chain stopped, signature registered and compared
// DONE    | bist_end high, results held, start begins a new session
module bist_controller
  import bist_pkg::*;
#(
  parameter int                   SIG_WIDTH   = BIST_SIG_WIDTH,
  parameter int                   SEED_WIDTH  = BIST_SEED_WIDTH,
  parameter int                   CNT_WIDTH   = BIST_CNT_WIDTH,
  parameter int                   TEST_CYCLES = 200,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bist_start,
  input  logic [SEED_WIDTH-1:0] lfsr_seed,
  input  logic [SIG_WIDTH-1:0]  signature_in,
  output logic [SEED_WIDTH-1:0] seed_out,
  output logic                  seed_load,
  output logic                  bist_mode,
  output logic                  chain_enable,
  output logic                  busy,
  output logic                  bist_end,
  output logic                  pass_fail,
  output logic [SIG_WIDTH-1:0]  signature_out
);

  localparam logic [SEED_WIDTH-1:0] SEED_SUBST = {SEED_WIDTH{SEED_SUBST_BIT}};

  // The run counter must not wrap within a run.
  generate
    if (TEST_CYCLES < 1 || TEST_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_test_cycles
      $error("bist_controller: TEST_CYCLES must be in 1..2**CNT_WIDTH-1");
    end
  endgenerate

  bist_state_e           state;
  logic                  run_tc;
  logic [SEED_WIDTH-1:0] seed_fixed;

  assign seed_fixed = (lfsr_seed == '0) ? SEED_SUBST : lfsr_seed;

  bist_run_counter #(
    .CNT_WIDTH  (CNT_WIDTH),
    .TEST_CYCLES(TEST_CYCLES)
  ) u_run_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_LOAD),
    .load    (1'b0),
    .load_val('0),
    .enable  (state == ST_RUN),
    .tc      (run_tc)
  );

`ifdef BIST_DOUBLE_RUN_EN
  logic [SEED_WIDTH-1:0] seed_q;
  logic [SIG_WIDTH-1:0]  sig_first;
  logic                  second_pass;
  logic                  cmp_stage;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      seed_out      <= '0;
      seed_load     <= 1'b0;
      bist_mode     <= 1'b0;
      chain_enable  <= 1'b0;
      busy          <= 1'b0;
      bist_end      <= 1'b0;
      pass_fail     <= 1'b0;
      signature_out <= '0;
`ifdef BIST_DOUBLE_RUN_EN
      seed_q        <= '0;
      sig_first     <= '0;
      second_pass   <= 1'b0;
      cmp_stage     <= 1'b0;
`endif
    end else begin
      // seed_out is only meaningful alongside the load strobe
      seed_load <= 1'b0;
      seed_out  <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            state     <= ST_LOAD;
            seed_out  <= seed_fixed;
            seed_load <= 1'b1;
            bist_mode <= 1'b1;
            busy      <= 1'b1;
            bist_end  <= 1'b0;
`ifdef BIST_DOUBLE_RUN_EN
            seed_q    <= seed_fixed;
`endif
          end
        end
        ST_LOAD: begin
          state        <= ST_RUN;
          chain_enable <= 1'b1;
        end
        ST_RUN: begin
          if (run_tc) begin
            state        <= ST_CAPTURE;
            chain_enable <= 1'b0;
          end
        end
        ST_CAPTURE: begin
`ifdef BIST_DOUBLE_RUN_EN
          if (!second_pass) begin
            // first signature kept, chain reloaded with the same seed
            sig_first   <= signature_in;
            second_pass <= 1'b1;
            seed_out    <= seed_q;
            seed_load   <= 1'b1;
            state       <= ST_LOAD;
          end else if (!cmp_stage) begin
            // register the second signature before the three-way compare
            signature_out <= signature_in;
            cmp_stage     <= 1'b1;
          end else begin
            pass_fail   <= (sig_first == GOLDEN_SIG) && (signature_out == GOLDEN_SIG) &&
                           (sig_first == signature_out);
            second_pass <= 1'b0;
            cmp_stage   <= 1'b0;
            bist_end    <= 1'b1;
            bist_mode   <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end
`else
          signature_out <= signature_in;
          pass_fail     <= (signature_in == GOLDEN_SIG);
          bist_end      <= 1'b1;
          bist_mode     <= 1'b0;
          busy          <= 1'b0;
          state         <= ST_DONE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller
// Directed sessions with randomized seeds/signatures, checked every cycle
// against a timing model expressed as offsets from the accepted start.
module tb_bist_controller;

  localparam int         TC   = 200;
  localparam logic [7:0] GOLD = 8'h5A;
`ifdef BIST_DOUBLE_RUN_EN
  localparam bit DOUBLE = 1'b1;
  localparam int END_K  = 2 * TC + 6;
`else
  localparam bit DOUBLE = 1'b0;
  localparam int END_K  = TC + 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bist_start = 1'b0;
  logic [3:0] lfsr_seed = 4'h0;
  logic [7:0] signature_in = 8'h00;
  logic [3:0] seed_out;
  logic       seed_load, bist_mode, chain_enable, busy, bist_end, pass_fail;
  logic [7:0] signature_out;

  bist_controller #(
    .SIG_WIDTH  (8),
    .SEED_WIDTH (4),
    .CNT_WIDTH  (8),
    .TEST_CYCLES(TC),
    .GOLDEN_SIG (GOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bist_start   (bist_start),
    .lfsr_seed    (lfsr_seed),
    .signature_in (signature_in),
    .seed_out     (seed_out),
    .seed_load    (seed_load),
    .bist_mode    (bist_mode),
    .chain_enable (chain_enable),
    .busy         (busy),
    .bist_end     (bist_end),
    .pass_fail    (pass_fail),
    .signature_out(signature_out)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int failed = 0;

  // mk: cycles since the accepted start (1 = LOAD cycle), -1 = idle after reset
  int         mk = -1;
  logic [3:0] m_seed = 4'h0;
  logic [7:0] m_sig = 8'h00;
  logic [7:0] m_first = 8'h00;
  logic       m_pass = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_act, e_load, e_chain;
    e_act   = (mk >= 1) && (mk < END_K);
    e_load  = (mk == 1) || (DOUBLE && mk == TC + 3);
    e_chain = (mk >= 2 && mk <= TC + 1) || (DOUBLE && mk >= TC + 4 && mk <= 2 * TC + 3);
    check("seed_load", 32'(seed_load), 32'(e_load));
    check("seed_out", 32'(seed_out), 32'(e_load ? m_seed : 4'h0));
    check("bist_mode", 32'(bist_mode), 32'(e_act));
    check("busy", 32'(busy), 32'(e_act));
    check("chain_enable", 32'(chain_enable), 32'(e_chain));
    check("bist_end", 32'(bist_end), 32'(mk == END_K));
    check("pass_fail", 32'(pass_fail), 32'(m_pass));
    check("signature_out", 32'(signature_out), 32'(m_sig));
  endtask

  // Applies the inputs that were present at the rising edge just taken.
  task automatic model_update();
    if (!reset) begin
      mk = -1; m_sig = 8'h00; m_pass = 1'b0;
    end else if (mk < 0 || mk == END_K) begin
      if (bist_start) begin
        mk = 1;
        m_seed = (lfsr_seed == 4'h0) ? 4'hF : lfsr_seed;
      end
    end else begin
      if (!DOUBLE && mk == TC + 2) begin
        m_sig  = signature_in;
        m_pass = (signature_in == GOLD);
      end
      if (DOUBLE && mk == TC + 2) m_first = signature_in;
      if (DOUBLE && mk == 2 * TC + 4) m_sig = signature_in;
      if (DOUBLE && mk == 2 * TC + 5) m_pass = (m_first == GOLD) && (m_sig == GOLD) && (m_first == m_sig);
      mk++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drive_sig(input int mode);
    case (mode)
      0:       signature_in = GOLD;
      1:       signature_in = GOLD ^ 8'h01;
      default: signature_in = ($urandom_range(1) == 1) ? GOLD : 8'($urandom);
    endcase
  endtask

  task automatic idle(input int n);
    bist_start = 1'b0;
    repeat (n) tick();
  endtask

  // One session from IDLE/DONE. poke_at re-pulses start while busy;
  // reset_at aborts with an asynchronous reset (offsets counted in cycles).
  task automatic session(input logic [3:0] seed, input int sig_mode, input int poke_at, input int reset_at);
    int lat;
    lfsr_seed  = seed;
    bist_start = 1'b1;
    drive_sig(sig_mode);
    tick();
    bist_start = 1'b0;
    lat = 1;
    while (bist_end !== 1'b1 && lat < END_K + 10) begin
      if (lat == reset_at) begin
        reset = 1'b0;
        mk = -1; m_sig = 8'h00; m_pass = 1'b0;
        #1;
        check_outputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("abort_no_end", 32'(bist_end), 32'(0));
        return;
      end
      bist_start = (lat == poke_at) || (sig_mode == 2 && $urandom_range(19) == 0);
      if (sig_mode == 2) lfsr_seed = 4'($urandom);
      drive_sig(sig_mode);
      tick();
      lat++;
    end
    bist_start = 1'b0;
    check("latency", 32'(lat), 32'(END_K));
  endtask

  initial begin
    reset = 1'b0;
    #1;
    check_outputs();
    tick();
    tick();
    reset = 1'b1;
    tick();

    session(4'hF, 0, -1, -1);
    idle(3);
    check("basic_pass_pf", 32'(pass_fail), 32'(1));
    check("basic_pass_sig", 32'(signature_out), 32'(GOLD));

    session(4'h3, 1, -1, -1);
    idle(2);
    check("fail_pf", 32'(pass_fail), 32'(0));
    check("fail_sig", 32'(signature_out), 32'(GOLD ^ 8'h01));

    session(4'h0, 0, -1, -1);
    session(4'h9, 0, 52, -1);
    session(4'h5, 2, -1, 102);
    idle(2);

    session(4'h7, 1, -1, -1);
    session(4'hA, 0, -1, -1);
    check("b2b_pf", 32'(pass_fail), 32'(1));

    for (int i = 0; i < 4; i++) begin
      session(4'($urandom), 2, -1, -1);
      idle(1);
    end

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
